// File: rtl/md_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// md_frame_sequencer_if
// Purpose : one AXI-stream channel (data, valid, ready, last) used for the
//           input stream and for both output ports of md_frame_sequencer.
// Signals : tdata  [DW-1:0] beat data
//           tvalid          beat valid (source -> sink)
//           tready          sink ready (sink -> source)
//           tlast           last beat of a packet (source -> sink)
// Modports: master drives tdata/tvalid/tlast and samples tready.
//           slave  samples tdata/tvalid and drives tready. tlast is left out
//           because the sequencer takes frame boundaries from its own
//           counters, not from the input stream.
// ---------------------------------------------------------------------------
interface md_frame_sequencer_if #(
  parameter int DW = 128
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/md_frame_sequencer.sv
// ---------------------------------------------------------------------------
// md_frame_sequencer
// Purpose : splits an input stream into frames. A frame is PACKET_LENGTH
//           header beats (only when i_md_enable was high at the frame
//           boundary), routed to m_md, followed by FRAME_SIZE payload beats,
//           routed to m_pl. Each output has a one-entry register and its own
//           tlast.
// Ports   : clk           rising-edge clock
//           resetn        synchronous, active-low reset
//           i_md_enable   header present for the next frame (sampled at
//                         frame boundaries and in IDLE only)
//           s_axis        input stream (slave)
//           m_md          metadata stream (master), tlast on last header beat
//           m_pl          payload stream (master), tlast on last payload beat
//           o_frame_count completed frames, wraps at 16 bits
//           o_in_frame    high from the first accepted beat of a frame until
//                         the cycle after its last payload beat (stays high
//                         when the next frame starts back to back)
// ---------------------------------------------------------------------------
module md_frame_sequencer #(
  parameter int DW            = 128,
  parameter int PACKET_LENGTH = 4,
  parameter int FRAME_SIZE    = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_md_enable,
  md_frame_sequencer_if.slave  s_axis,
  md_frame_sequencer_if.master m_md,
  md_frame_sequencer_if.master m_pl,
  output logic [15:0]          o_frame_count,
  output logic                 o_in_frame
);

  localparam logic [15:0] C_HDR_LAST = 16'(PACKET_LENGTH - 1);
  localparam logic [15:0] C_PLD_LAST = 16'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PLD  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_beat_cnt;
  logic [DW-1:0] r_md_data;
  logic          r_md_valid;
  logic          r_md_last;
  logic [DW-1:0] r_pl_data;
  logic          r_pl_valid;
  logic          r_pl_last;
  logic [15:0]   r_frame_count;
  logic          r_in_frame;
  logic          r_frame_done;

  logic [DW-1:0] w_in_data;
  logic          w_md_free;
  logic          w_pl_free;
  logic          w_ready;
  logic          w_md_load;
  logic          w_pl_load;
  logic          w_hdr_last;
  logic          w_pld_last;
  logic          w_accept;

  assign w_in_data = s_axis.tdata;

  // A register slot can take a new beat when it is empty or being drained
  // on this same edge.
  assign w_md_free = !r_md_valid || m_md.tready;
  assign w_pl_free = !r_pl_valid || m_pl.tready;

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_md_load    = 1'b0;
    w_pl_load    = 1'b0;
    w_hdr_last   = 1'b0;
    w_pld_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = i_md_enable ? ST_HDR : ST_PLD;
      end
      ST_HDR: begin
        w_ready   = w_md_free;
        w_md_load = s_axis.tvalid && w_md_free;
        if (w_md_load && (r_beat_cnt == C_HDR_LAST)) begin
          w_hdr_last   = 1'b1;
          w_state_next = ST_PLD;
        end
      end
      ST_PLD: begin
        w_ready   = w_pl_free;
        w_pl_load = s_axis.tvalid && w_pl_free;
        if (w_pl_load && (r_beat_cnt == C_PLD_LAST)) begin
          w_pld_last   = 1'b1;
          // Header presence of the next frame is decided here, at the boundary.
          w_state_next = i_md_enable ? ST_HDR : ST_PLD;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_accept = w_md_load || w_pl_load;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_beat_cnt    <= '0;
      r_md_data     <= '0;
      r_md_valid    <= 1'b0;
      r_md_last     <= 1'b0;
      r_pl_data     <= '0;
      r_pl_valid    <= 1'b0;
      r_pl_last     <= 1'b0;
      r_frame_count <= '0;
      r_in_frame    <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Clearing on the last beat of each section also covers the
      // payload-to-payload frame boundary, where the state does not change.
      if ((r_state == ST_IDLE) || w_hdr_last || w_pld_last) begin
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end

      if (w_md_load) begin
        r_md_data  <= w_in_data;
        r_md_valid <= 1'b1;
        r_md_last  <= w_hdr_last;
      end else if (m_md.tready) begin
        r_md_valid <= 1'b0;
      end

      if (w_pl_load) begin
        r_pl_data  <= w_in_data;
        r_pl_valid <= 1'b1;
        r_pl_last  <= w_pld_last;
      end else if (m_pl.tready) begin
        r_pl_valid <= 1'b0;
      end

      if (w_pld_last) begin
        r_frame_count <= r_frame_count + 16'd1;
      end

      // in_frame drops one cycle after the final payload beat, unless a new
      // frame's first beat is accepted in that cycle.
      r_frame_done <= w_pld_last;
      if (w_accept) begin
        r_in_frame <= 1'b1;
      end else if (r_frame_done) begin
        r_in_frame <= 1'b0;
      end
    end
  end

  assign s_axis.tready = w_ready;
  assign m_md.tdata    = r_md_data;
  assign m_md.tvalid   = r_md_valid;
  assign m_md.tlast    = r_md_last;
  assign m_pl.tdata    = r_pl_data;
  assign m_pl.tvalid   = r_pl_valid;
  assign m_pl.tlast    = r_pl_last;
  assign o_frame_count = r_frame_count;
  assign o_in_frame    = r_in_frame;

endmodule

// File: tb/tb_md_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_frame_sequencer
// Purpose : self-checking bench for md_frame_sequencer. A frame-level model
//           (beat index within frame, header flag, port occupancy) predicts
//           what each port should deliver; delivered beats are collected and
//           compared per scenario. A second instance with one-beat frames
//           checks the frame counter wrap.
// ---------------------------------------------------------------------------
module tb_md_frame_sequencer;

  localparam int PKT = 2;
  localparam int FS  = 4;

  typedef struct packed {
    logic         last;
    logic [127:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        md_en;
  logic [15:0] frame_count;
  logic        in_frame;

  logic        resetn2;
  logic        md_en2;
  logic [15:0] frame_count2;
  logic        in_frame2;

  md_frame_sequencer_if #(.DW(128)) s_if ();
  md_frame_sequencer_if #(.DW(128)) md_if ();
  md_frame_sequencer_if #(.DW(128)) pl_if ();
  md_frame_sequencer_if #(.DW(128)) w_s ();
  md_frame_sequencer_if #(.DW(128)) w_md ();
  md_frame_sequencer_if #(.DW(128)) w_pl ();

  md_frame_sequencer #(.DW(128), .PACKET_LENGTH(PKT), .FRAME_SIZE(FS)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_md_enable   (md_en),
    .s_axis        (s_if),
    .m_md          (md_if),
    .m_pl          (pl_if),
    .o_frame_count (frame_count),
    .o_in_frame    (in_frame)
  );

  md_frame_sequencer #(.DW(128), .PACKET_LENGTH(1), .FRAME_SIZE(1)) dut_wrap (
    .clk           (clk),
    .resetn        (resetn2),
    .i_md_enable   (md_en2),
    .s_axis        (w_s),
    .m_md          (w_md),
    .m_pl          (w_pl),
    .o_frame_count (frame_count2),
    .o_in_frame    (in_frame2)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  bit    mdl_idle;
  bit    mdl_hdr;
  int    mdl_idx;
  bit    mdl_md_occ;
  bit    mdl_pl_occ;
  int    mdl_fc;
  bit    mdl_inf;
  beat_t exp_md[$];
  beat_t exp_pl[$];
  beat_t obs_md[$];
  beat_t obs_pl[$];

  // Per-cycle observations
  int    ready_err, valid_err, stab_err, fc_err, inf_err, acc_cnt;
  bit    md_seen_valid;
  bit    last_ready;
  bit    md_stall, pl_stall;
  beat_t prev_md, prev_pl;
  int    nxt;

  task automatic clear_stats();
    ready_err     = 0;
    valid_err     = 0;
    stab_err      = 0;
    fc_err        = 0;
    inf_err       = 0;
    acc_cnt       = 0;
    md_seen_valid = 1'b0;
  endtask

  function automatic int model_diff();
    int n = 0;
    if (obs_md.size() != exp_md.size()) n++;
    if (obs_pl.size() != exp_pl.size()) n++;
    for (int i = 0; i < obs_md.size() && i < exp_md.size(); i++)
      if (obs_md[i] !== exp_md[i]) n++;
    for (int i = 0; i < obs_pl.size() && i < exp_pl.size(); i++)
      if (obs_pl[i] !== exp_pl[i]) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs at the falling edge, observe the DUT just
  // after, then advance the frame model across the rising edge.
  task automatic cycle(input bit rst, input bit v, input logic [127:0] d,
                       input bit en, input bit mdr, input bit plr);
    bit in_hdr, exp_rdy, hs, md_load, pl_load, last;
    int hlen;
    @(negedge clk);
    resetn       = !rst;
    s_if.tvalid  = v;
    s_if.tdata   = d;
    md_en        = en;
    md_if.tready = mdr;
    pl_if.tready = plr;
    #1;
    last_ready = s_if.tready;
    hlen    = mdl_hdr ? PKT : 0;
    in_hdr  = (mdl_idx < hlen);
    exp_rdy = mdl_idle ? 1'b0 : (in_hdr ? (!mdl_md_occ || mdr) : (!mdl_pl_occ || plr));
    if (!rst) begin
      if (s_if.tready !== exp_rdy) ready_err++;
      if (md_if.tvalid !== mdl_md_occ) valid_err++;
      if (pl_if.tvalid !== mdl_pl_occ) valid_err++;
      if (frame_count !== 16'(mdl_fc)) fc_err++;
      if (in_frame !== mdl_inf) inf_err++;
      if (md_if.tvalid === 1'b1) md_seen_valid = 1'b1;
      if (md_stall && (md_if.tvalid !== 1'b1 || {md_if.tlast, md_if.tdata} !== prev_md)) stab_err++;
      if (pl_stall && (pl_if.tvalid !== 1'b1 || {pl_if.tlast, pl_if.tdata} !== prev_pl)) stab_err++;
      md_stall = md_if.tvalid && !mdr;
      pl_stall = pl_if.tvalid && !plr;
      prev_md  = {md_if.tlast, md_if.tdata};
      prev_pl  = {pl_if.tlast, pl_if.tdata};
      if (md_if.tvalid && mdr) obs_md.push_back({md_if.tlast, md_if.tdata});
      if (pl_if.tvalid && plr) obs_pl.push_back({pl_if.tlast, pl_if.tdata});
    end else begin
      md_stall = 1'b0;
      pl_stall = 1'b0;
    end
    hs = !rst && v && exp_rdy;
    if (hs) begin
      acc_cnt++;
      nxt++;
    end
    @(posedge clk);
    if (rst) begin
      mdl_idle   = 1'b1;
      mdl_hdr    = 1'b0;
      mdl_idx    = 0;
      mdl_md_occ = 1'b0;
      mdl_pl_occ = 1'b0;
      mdl_fc     = 0;
      mdl_inf    = 1'b0;
      exp_md.delete();
      exp_pl.delete();
      obs_md.delete();
      obs_pl.delete();
      return;
    end
    md_load = 1'b0;
    pl_load = 1'b0;
    if (mdl_idle) begin
      mdl_idle = 1'b0;
      mdl_hdr  = en;
    end else if (hs) begin
      last = 1'b0;
      if (in_hdr) begin
        exp_md.push_back({(mdl_idx == PKT - 1), d});
        md_load = 1'b1;
      end else begin
        last = (mdl_idx - hlen == FS - 1);
        exp_pl.push_back({last, d});
        pl_load = 1'b1;
      end
      mdl_idx++;
      if (last) begin
        mdl_fc  = (mdl_fc + 1) % 65536;
        mdl_idx = 0;
        mdl_hdr = en;
      end
    end
    mdl_md_occ = md_load || (mdl_md_occ && !mdr);
    mdl_pl_occ = pl_load || (mdl_pl_occ && !plr);
    mdl_inf    = hs || (mdl_idx != 0);
  endtask

  task automatic test_reset();
    clear_stats();
    cycle(1, 0, '0, 0, 0, 0);
    cycle(1, 0, '0, 0, 0, 0);
    #1;
    n_chk++;
    if ({md_if.tvalid, md_if.tlast, pl_if.tvalid, pl_if.tlast} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 0000",
               {md_if.tvalid, md_if.tlast, pl_if.tvalid, pl_if.tlast});
    end
    n_chk++;
    if (md_if.tdata !== '0 || pl_if.tdata !== '0) begin
      n_err++;
      $display("FAIL reset_tdata: got md=%0h pl=%0h required 0", md_if.tdata, pl_if.tdata);
    end
    n_chk++;
    if (frame_count !== 16'd0 || in_frame !== 1'b0) begin
      n_err++;
      $display("FAIL reset_counters: got fc=%0d in_frame=%b required 0/0", frame_count, in_frame);
    end
    cycle(0, 1, 128'h77, 1, 1, 1);
    n_chk++;
    if (last_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ready: got %b required 0", last_ready);
    end
    $display("test_reset done: checks=%0d errors=%0d", n_chk, n_err);
  endtask

  task automatic test_back_to_back();
    int rdy_cnt = 0;
    int md_val[4] = '{0, 1, 6, 7};
    clear_stats();
    cycle(1, 0, '0, 1, 1, 1);
    cycle(0, 1, '0, 1, 1, 1);
    nxt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 128'(nxt), 1, 1, 1);
      rdy_cnt += int'(last_ready);
    end
    cycle(0, 0, '0, 1, 1, 1);
    cycle(0, 0, '0, 1, 1, 1);
    n_chk++;
    if (rdy_cnt != 12) begin
      n_err++;
      $display("FAIL b2b_no_bubble: got %0d ready cycles required 12", rdy_cnt);
    end
    n_chk++;
    if (obs_md.size() != 4 || obs_pl.size() != 8) begin
      n_err++;
      $display("FAIL b2b_counts: got md=%0d pl=%0d required 4/8", obs_md.size(), obs_pl.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (obs_md[i].data !== 128'(md_val[i]) || obs_md[i].last !== (i % 2 == 1)) begin
          n_err++;
          $display("FAIL b2b_md[%0d]: got %0h/%b required %0h/%b", i, obs_md[i].data,
                   obs_md[i].last, md_val[i], (i % 2 == 1));
        end
      end
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (obs_pl[i].data !== 128'(i + 2 + ((i >= 4) ? 2 : 0)) || obs_pl[i].last !== (i % 4 == 3)) begin
          n_err++;
          $display("FAIL b2b_pl[%0d]: got %0h/%b required %0h/%b", i, obs_pl[i].data,
                   obs_pl[i].last, i + 2 + ((i >= 4) ? 2 : 0), (i % 4 == 3));
        end
      end
    end
    n_chk++;
    if (frame_count !== 16'd2) begin
      n_err++;
      $display("FAIL b2b_frame_count: got %0d required 2", frame_count);
    end
    n_chk++;
    if (ready_err + valid_err + stab_err + fc_err + inf_err != 0) begin
      n_err++;
      $display("FAIL b2b_protocol: got rdy=%0d vld=%0d stab=%0d fc=%0d inf=%0d required 0",
               ready_err, valid_err, stab_err, fc_err, inf_err);
    end
    $display("test_back_to_back done: checks=%0d errors=%0d", n_chk, n_err);
  endtask

  task automatic test_md_disabled();
    clear_stats();
    cycle(1, 0, '0, 0, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);
    nxt = 32;
    for (int i = 0; i < 8; i++) cycle(0, 1, 128'(nxt), 0, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);
    n_chk++;
    if (md_seen_valid !== 1'b0) begin
      n_err++;
      $display("FAIL nohdr_md_valid: got md_tvalid seen=1 required 0");
    end
    n_chk++;
    if (obs_pl.size() != 8) begin
      n_err++;
      $display("FAIL nohdr_pl_count: got %0d required 8", obs_pl.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (obs_pl[i].data !== 128'(32 + i) || obs_pl[i].last !== (i == 3 || i == 7)) begin
          n_err++;
          $display("FAIL nohdr_pl[%0d]: got %0h/%b required %0h/%b", i, obs_pl[i].data,
                   obs_pl[i].last, 32 + i, (i == 3 || i == 7));
        end
      end
    end
    n_chk++;
    if (frame_count !== 16'd2) begin
      n_err++;
      $display("FAIL nohdr_frame_count: got %0d required 2", frame_count);
    end
    $display("test_md_disabled done: checks=%0d errors=%0d", n_chk, n_err);
  endtask

  task automatic test_md_toggle();
    clear_stats();
    cycle(1, 0, '0, 1, 1, 1);
    cycle(0, 0, '0, 1, 1, 1);
    nxt = 0;
    cycle(0, 1, 128'(nxt), 1, 1, 1);
    for (int i = 1; i < 10; i++) cycle(0, 1, 128'(nxt), 0, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);
    n_chk++;
    if (obs_md.size() != 2 || obs_pl.size() != 8) begin
      n_err++;
      $display("FAIL toggle_counts: got md=%0d pl=%0d required 2/8", obs_md.size(), obs_pl.size());
    end else begin
      n_chk++;
      if (obs_md[0].data !== 128'd0 || obs_md[1].data !== 128'd1 || obs_md[1].last !== 1'b1) begin
        n_err++;
        $display("FAIL toggle_hdr: got %0h,%0h last=%b required 0,1 last=1",
                 obs_md[0].data, obs_md[1].data, obs_md[1].last);
      end
      n_chk++;
      if (obs_pl[4].data !== 128'd6 || obs_pl[7].data !== 128'd9 || obs_pl[7].last !== 1'b1) begin
        n_err++;
        $display("FAIL toggle_frame2: got %0h..%0h last=%b required 6..9 last=1",
                 obs_pl[4].data, obs_pl[7].data, obs_pl[7].last);
      end
    end
    n_chk++;
    if (model_diff() != 0) begin
      n_err++;
      $display("FAIL toggle_model: got %0d differing beats required 0", model_diff());
    end
    $display("test_md_toggle done: checks=%0d errors=%0d", n_chk, n_err);
  endtask

  task automatic test_backpressure();
    int stalled_ready = 0;
    int hdr_ready = 0;
    int guard = 0;
    clear_stats();
    cycle(1, 0, '0, 1, 0, 1);
    cycle(0, 0, '0, 1, 0, 1);
    nxt = 'h50;
    cycle(0, 1, 128'(nxt), 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 128'(nxt), 1, 0, 1);
      stalled_ready += int'(last_ready);
    end
    #1;
    n_chk++;
    if (stalled_ready != 0) begin
      n_err++;
      $display("FAIL bp_ready_drop: got %0d ready cycles while held required 0", stalled_ready);
    end
    n_chk++;
    if (md_if.tvalid !== 1'b1 || md_if.tdata !== 128'h50) begin
      n_err++;
      $display("FAIL bp_held_beat: got valid=%b data=%0h required 1/50", md_if.tvalid, md_if.tdata);
    end
    while (nxt < 'h56 && guard < 40) begin
      cycle(0, 1, 128'(nxt), 1, 1, 1);
      guard++;
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 128'(nxt), 1, 1, 0);
      hdr_ready += int'(last_ready);
    end
    cycle(0, 0, '0, 1, 1, 1);
    cycle(0, 0, '0, 1, 1, 1);
    n_chk++;
    if (hdr_ready != 2) begin
      n_err++;
      $display("FAIL bp_pl_independent: got %0d header ready cycles required 2", hdr_ready);
    end
    n_chk++;
    if (model_diff() != 0 || stab_err != 0) begin
      n_err++;
      $display("FAIL bp_model: got diff=%0d stab=%0d required 0/0", model_diff(), stab_err);
    end
    $display("test_backpressure done: checks=%0d errors=%0d", n_chk, n_err);
  endtask

  task automatic test_reset_midframe();
    clear_stats();
    cycle(1, 0, '0, 1, 1, 1);
    cycle(0, 0, '0, 1, 1, 1);
    nxt = 'h10;
    for (int i = 0; i < 4; i++) cycle(0, 1, 128'(nxt), 1, 1, 1);
    cycle(0, 0, '0, 1, 1, 0);
    cycle(1, 0, '0, 1, 0, 0);
    #1;
    n_chk++;
    if ({md_if.tvalid, md_if.tlast, pl_if.tvalid, pl_if.tlast, in_frame} !== 5'b0 ||
        frame_count !== 16'd0 || pl_if.tdata !== '0 || s_if.tready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got vld/last=%b fc=%0d pl_data=%0h rdy=%b required zeros",
               {md_if.tvalid, md_if.tlast, pl_if.tvalid, pl_if.tlast, in_frame},
               frame_count, pl_if.tdata, s_if.tready);
    end
    clear_stats();
    cycle(0, 0, '0, 1, 1, 1);
    nxt = 'h100;
    for (int i = 0; i < 6; i++) cycle(0, 1, 128'(nxt), 1, 1, 1);
    cycle(0, 0, '0, 1, 1, 1);
    cycle(0, 0, '0, 1, 1, 1);
    n_chk++;
    if (obs_md.size() < 1 || obs_md[0].data !== 128'h100 || obs_md[0].last !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_first_hdr: got n=%0d data=%0h required header beat 0 = 100",
               obs_md.size(), (obs_md.size() > 0) ? obs_md[0].data : '0);
    end
    n_chk++;
    if (model_diff() != 0 || obs_pl.size() != 4) begin
      n_err++;
      $display("FAIL midreset_model: got diff=%0d pl=%0d required 0/4", model_diff(), obs_pl.size());
    end
    $display("test_reset_midframe done: checks=%0d errors=%0d", n_chk, n_err);
  endtask

  task automatic test_random();
    clear_stats();
    cycle(1, 0, '0, 1, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle(0, ($urandom_range(0, 3) != 0),
            {$urandom(), $urandom(), $urandom(), $urandom()},
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end
    cycle(0, 0, '0, 0, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);
    n_chk++;
    if (model_diff() != 0) begin
      n_err++;
      $display("FAIL rand_model: got %0d differing beats (md %0d/%0d pl %0d/%0d) required 0",
               model_diff(), obs_md.size(), exp_md.size(), obs_pl.size(), exp_pl.size());
    end
    n_chk++;
    if (ready_err + valid_err + stab_err + fc_err + inf_err != 0) begin
      n_err++;
      $display("FAIL rand_protocol: got rdy=%0d vld=%0d stab=%0d fc=%0d inf=%0d required 0",
               ready_err, valid_err, stab_err, fc_err, inf_err);
    end
    n_chk++;
    if (acc_cnt < 1000) begin
      n_err++;
      $display("FAIL rand_throughput: got %0d accepted beats required at least 1000", acc_cnt);
    end
    $display("test_random done: accepted=%0d checks=%0d errors=%0d", acc_cnt, n_chk, n_err);
  endtask

  task automatic test_frame_count_wrap();
    int acc = 0;
    int cyc = 0;
    int md_vld = 0;
    int pl_nolast = 0;
    @(negedge clk);
    resetn2      = 1'b0;
    w_s.tvalid   = 1'b0;
    w_md.tready  = 1'b1;
    w_pl.tready  = 1'b1;
    md_en2       = 1'b0;
    @(negedge clk);
    resetn2    = 1'b1;
    w_s.tvalid = 1'b1;
    while (acc < 65535 && cyc < 70000) begin
      @(negedge clk);
      w_s.tdata = 128'(cyc);
      #1;
      if (w_s.tready === 1'b1) acc++;
      if (w_md.tvalid === 1'b1) md_vld++;
      if (w_pl.tvalid === 1'b1 && w_pl.tlast !== 1'b1) pl_nolast++;
      cyc++;
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (acc != 65535 || frame_count2 !== 16'd65535) begin
      n_err++;
      $display("FAIL wrap_pre: got acc=%0d fc=%0d required 65535/65535", acc, frame_count2);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (w_s.tready !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_ready: got %b required 1", w_s.tready);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (frame_count2 !== 16'd0 || in_frame2 !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_zero: got fc=%0d in_frame=%b required 0/1", frame_count2, in_frame2);
    end
    n_chk++;
    if (md_vld != 0 || pl_nolast != 0) begin
      n_err++;
      $display("FAIL wrap_ports: got md_valid=%0d pl_without_last=%0d required 0/0", md_vld, pl_nolast);
    end
    @(negedge clk);
    w_s.tvalid = 1'b0;
    $display("test_frame_count_wrap done: cycles=%0d checks=%0d errors=%0d", cyc, n_chk, n_err);
  endtask

  initial begin
    resetn       = 1'b0;
    md_en        = 1'b0;
    s_if.tvalid  = 1'b0;
    s_if.tdata   = '0;
    s_if.tlast   = 1'b0;
    md_if.tready = 1'b0;
    pl_if.tready = 1'b0;
    resetn2      = 1'b0;
    md_en2       = 1'b0;
    w_s.tvalid   = 1'b0;
    w_s.tdata    = '0;
    w_s.tlast    = 1'b0;
    w_md.tready  = 1'b1;
    w_pl.tready  = 1'b1;
    md_stall     = 1'b0;
    pl_stall     = 1'b0;
    nxt          = 0;
    mdl_idle     = 1'b1;
    mdl_hdr      = 1'b0;
    mdl_idx      = 0;
    mdl_md_occ   = 1'b0;
    mdl_pl_occ   = 1'b0;
    mdl_fc       = 0;
    mdl_inf      = 1'b0;
    test_reset();
    test_back_to_back();
    test_md_disabled();
    test_md_toggle();
    test_backpressure();
    test_reset_midframe();
    test_random();
    test_frame_count_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/md_frame_sequencer.md
# md_frame_sequencer

Frame-level sequencer for the metadata path. It takes one AXI-stream of 128-bit beats and splits every frame into two parts. The first PACKET_LENGTH beats are metadata and go to the metadata port. The next FRAME_SIZE beats are payload and go to the payload port. Each output port carries its own tlast, and the block counts frames and applies full backpressure. It sits between the acquisition stream and the metadata/payload consumers, and it owns the frame boundary decision that the downstream splitting logic needs.

## Interface
- DW, 128, data width of all streams.
- PACKET_LENGTH, 4, metadata beats per frame; legal range 1 to 65535.
- FRAME_SIZE, 1024, payload beats per frame; legal range 1 to 65535.
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- md_enable  in  1  header present for the next frame; sampled only at frame boundaries.
- s_tdata  in  DW  input beat.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_md_tdata  out  DW  metadata beat (registered).
- m_md_tvalid  out  1  metadata valid.
- m_md_tlast  out  1  high on the last header beat of a frame.
- m_md_tready  in  1  metadata consumer ready.
- m_pl_tdata  out  DW  payload beat (registered).
- m_pl_tvalid  out  1  payload valid.
- m_pl_tlast  out  1  high on payload beat FRAME_SIZE-1.
- m_pl_tready  in  1  payload consumer ready.
- frame_count  out  16  number of completed frames; wraps 65535 -> 0.
- in_frame  out  1  high from the first accepted beat of a frame through the last accepted payload beat.

## Operation
- States:
  - IDLE: entered after reset, lasts 1 cycle, s_tready=0.
  - HDR: routes accepted beats to the metadata port.
  - PLD: routes accepted beats to the payload port.
- From IDLE, the next state is md_enable ? HDR : PLD.
- Beat counter is 16 bits, cleared on every state change, and increments on each input handshake (s_tvalid && s_tready).
- HDR: on acceptance of beat PACKET_LENGTH-1, set m_md_tlast=1 on that beat and go to PLD.
- PLD: on acceptance of beat FRAME_SIZE-1, set m_pl_tlast=1 on that beat. The next state is md_enable ? HDR : PLD, using md_enable in that same cycle.
- With md_enable=0 a frame is payload only: FRAME_SIZE beats, nothing on the metadata port.
- md_enable changes mid-frame are ignored.
- Each output port has a one-entry register.
  - slot_free = !m_x_tvalid || m_x_tready.
  - s_tready = slot_free of the port selected by the current state. It is 0 in IDLE.
  - s_tready depends combinationally on m_x_tready; this is the only combinational input-to-output path.
- The two output registers are independent. The last header beat may stall in the metadata register while payload beats flow, and vice versa.
- frame_count increments on input acceptance of the payload tlast beat.
- in_frame rises with the first accepted beat of a frame. It falls in the cycle after the payload tlast beat is accepted, unless the next frame's first beat is accepted in that cycle.
- tdata passes through unmodified. tdata in an empty register is don't-care and is driven 0 after reset.

## Timing
- Reset values:
  - state IDLE; counter 0.
  - all m_*_tvalid, m_*_tlast, m_*_tdata = 0.
  - s_tready 0, frame_count 0, in_frame 0.
- Reset mid-frame: held beats are discarded without being presented, counters clear, and the next frame starts fresh after IDLE.
- Latency: a beat accepted at edge N is valid on its port after edge N.
- Throughput: 1 beat/cycle when the selected consumer holds tready=1. There is no bubble at the HDR<->PLD transition or at the frame boundary.
- Simultaneous drain and fill of the same register: the old beat transfers and the new beat loads on the same edge.
- Stability: m_x_tvalid/tdata/tlast hold stable while tvalid=1 and tready=0.
- Backpressure on the port not selected never affects s_tready.

## Test plan
- Params PACKET_LENGTH=2, FRAME_SIZE=4; md_enable=1; both treadys=1; beats 0..11 back-to-back:
  - md port gets 0,1 / 6,7 with tlast on 1 / 7.
  - pl port gets 2..5 / 8..11 with tlast on 5 / 11.
  - frame_count 0 -> 2; no idle cycles after IDLE.
- md_enable=0 throughout, 8 beats: all go to pl, tlast on beats 3 and 7, md_tvalid never 1, frame_count=2.
- md_enable toggled 1->0 during beat 1 of frame 1:
  - frame 1 keeps its header.
  - frame 2, sampled at frame 1's tlast, has no header: beats 6..9 to pl.
- m_md_tready=0 for 10 cycles during the header:
  - s_tready drops after 1 md beat is held.
  - no data lost or duplicated; tdata held stable.
  - pl backpressure is independent: m_pl_tready=0 with md free does not stall the header.
- resetn=0 for 1 cycle after beat 3 of a frame:
  - all outputs return to reset values.
  - the next accepted beat is treated as header beat 0.
- frame_count wrap: preload via 65536 frames with FRAME_SIZE=1, PACKET_LENGTH=1 -> frame_count returns to 0.
